decstage_pipe: RTL and testbench

Parametrised decode stage with an integrated ID/EX pipeline register. It decodes a 32-bit MIPS-format instruction, reads two operands from an internal register file and produces an immediate under a selectable extension mode. Results are registered behind a valid/ready handshake with stall and flush. It sits between the fetch stage and the execute stage; the write-back stage drives its write port.

---
 rtl/decstage_pkg.sv | 23 ++
 rtl/reg_file_param.sv | 48 ++++
 rtl/decstage_pipe.sv | 109 ++++++++++
 tb/tb_decstage_pipe.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/decstage_pkg.sv
// Shared constants for the decode stage: immediate modes, instruction field positions
// and the register-index width helper.
package decstage_pkg;

    typedef enum logic [1:0] {
        IMM_ZERO = 2'b00,
        IMM_SIGN = 2'b01,
        IMM_LUI  = 2'b10,
        IMM_BR   = 2'b11
    } imm_mode_e;

    localparam int INSTR_W = 32;
    localparam int RS_LSB  = 21;
    localparam int RT_LSB  = 16;
    localparam int RD_LSB  = 11;
    localparam int IMM_LSB = 0;
    localparam int IMM_W   = 16;

    function automatic int calc_aw(input int reg_num);
        return (reg_num <= 2) ? 1 : $clog2(reg_num);
    endfunction

endpackage

// File: rtl/reg_file_param.sv
// Register file with two asynchronous read ports and one synchronous write port.
// Register 0 reads as zero. Optional write-through bypass under DECSTAGE_BYPASS_EN.
module reg_file_param
    import decstage_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int REG_NUM = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [calc_aw(REG_NUM)-1:0]   rd_addr_a,
    input  logic [calc_aw(REG_NUM)-1:0]   rd_addr_b,
    output logic [DATA_W-1:0]             rd_data_a,
    output logic [DATA_W-1:0]             rd_data_b,
    input  logic                          wr_en,
    input  logic [calc_aw(REG_NUM)-1:0]   wr_addr,
    input  logic [DATA_W-1:0]             wr_data
);

    localparam int AW = calc_aw(REG_NUM);

    logic [DATA_W-1:0] mem [REG_NUM];
    logic              hit_a;
    logic              hit_b;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < REG_NUM; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en && (wr_addr != AW'(0))) begin
            mem[wr_addr] <= wr_data;
        end
    end

`ifdef DECSTAGE_BYPASS_EN
    assign hit_a = wr_en && (wr_addr == rd_addr_a);
    assign hit_b = wr_en && (wr_addr == rd_addr_b);
`else
    // Without bypass the reader sees the pre-write value; the issuing side owns the bubble.
    assign hit_a = 1'b0;
    assign hit_b = 1'b0;
`endif

    assign rd_data_a = (rd_addr_a == AW'(0)) ? '0 : (hit_a ? wr_data : mem[rd_addr_a]);
    assign rd_data_b = (rd_addr_b == AW'(0)) ? '0 : (hit_b ? wr_data : mem[rd_addr_b]);

endmodule

// File: rtl/decstage_pipe.sv
// Decode stage with ID/EX output register behind a valid/ready handshake.
// Optional same-cycle write-through bypass: define DECSTAGE_BYPASS_EN.
module decstage_pipe
    import decstage_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int REG_NUM = 32
) (
    input  logic                          Clk,
    input  logic                          Rst,
    input  logic                          In_valid,
    output logic                          In_ready,
    input  logic [31:0]                   Instr,
    input  logic                          RF_B_sel,
    input  logic [1:0]                    Imm_mode,
    input  logic                          Wb_WrEn,
    input  logic [calc_aw(REG_NUM)-1:0]   Wb_Addr,
    input  logic [DATA_W-1:0]             Wb_Data,
    input  logic                          Flush,
    output logic                          Out_valid,
    input  logic                          Out_ready,
    output logic [DATA_W-1:0]             Immed,
    output logic [DATA_W-1:0]             RF_A,
    output logic [DATA_W-1:0]             RF_B,
    output logic [calc_aw(REG_NUM)-1:0]   Rt_addr
);

    localparam int AW = calc_aw(REG_NUM);

    logic [AW-1:0]     rs_idx;
    logic [AW-1:0]     rt_idx;
    logic [AW-1:0]     rd_idx;
    logic [AW-1:0]     rb_idx;
    logic [IMM_W-1:0]  imm;
    logic [DATA_W-1:0] zext;
    logic [DATA_W-1:0] sext;
    logic [DATA_W-1:0] imm_ext;
    logic [DATA_W-1:0] rd_a;
    logic [DATA_W-1:0] rd_b;
    logic              accept;
    logic              unused_instr_bits;

    assign rs_idx = Instr[RS_LSB +: AW];
    assign rt_idx = Instr[RT_LSB +: AW];
    assign rd_idx = Instr[RD_LSB +: AW];
    assign rb_idx = RF_B_sel ? rt_idx : rd_idx;
    assign imm    = Instr[IMM_LSB +: IMM_W];

    // Opcode/funct bits and unused index bits are not decoded here.
    assign unused_instr_bits = ^Instr;

    assign zext = {{(DATA_W-IMM_W){1'b0}}, imm};
    assign sext = {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};

    always_comb begin
        imm_ext = zext;
        case (imm_mode_e'(Imm_mode))
            IMM_ZERO: imm_ext = zext;
            IMM_SIGN: imm_ext = sext;
            IMM_LUI:  imm_ext = zext << 16;
            IMM_BR:   imm_ext = sext << 2;
            default:  imm_ext = zext;
        endcase
    end

    reg_file_param #(
        .DATA_W  (DATA_W),
        .REG_NUM (REG_NUM)
    ) u_rf (
        .clk       (Clk),
        .rst       (Rst),
        .rd_addr_a (rs_idx),
        .rd_addr_b (rb_idx),
        .rd_data_a (rd_a),
        .rd_data_b (rd_b),
        .wr_en     (Wb_WrEn),
        .wr_addr   (Wb_Addr),
        .wr_data   (Wb_Data)
    );

    assign In_ready = !Out_valid || Out_ready;
    assign accept   = In_valid && In_ready;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            Out_valid <= 1'b0;
            Immed     <= '0;
            RF_A      <= '0;
            RF_B      <= '0;
            Rt_addr   <= '0;
        end else begin
            if (Flush) begin
                Out_valid <= 1'b0;
            end else if (accept) begin
                Out_valid <= 1'b1;
            end else if (Out_ready) begin
                Out_valid <= 1'b0;
            end
            // A flushed instruction never lands, so the data fields keep their last value.
            if (accept && !Flush) begin
                Immed   <= imm_ext;
                RF_A    <= rd_a;
                RF_B    <= rd_b;
                Rt_addr <= rt_idx;
            end
        end
    end

endmodule

// File: tb/tb_decstage_pipe.sv
// Directed plus randomized bench for decstage_pipe against a behavioural model.
module tb_decstage_pipe;

    logic        Clk = 1'b0;
    logic        Rst;
    logic        In_valid;
    logic        In_ready;
    logic [31:0] Instr;
    logic        RF_B_sel;
    logic [1:0]  Imm_mode;
    logic        Wb_WrEn;
    logic [4:0]  Wb_Addr;
    logic [31:0] Wb_Data;
    logic        Flush;
    logic        Out_valid;
    logic        Out_ready;
    logic [31:0] Immed;
    logic [31:0] RF_A;
    logic [31:0] RF_B;
    logic [4:0]  Rt_addr;

    int checks   = 0;
    int failures = 0;

    logic [31:0] ref_rf [32];
    logic        m_valid;
    logic [31:0] m_imm_q;
    logic [31:0] m_a;
    logic [31:0] m_b;
    logic [4:0]  m_rt;

    decstage_pipe #(.DATA_W(32), .REG_NUM(32)) dut (
        .Clk       (Clk),
        .Rst       (Rst),
        .In_valid  (In_valid),
        .In_ready  (In_ready),
        .Instr     (Instr),
        .RF_B_sel  (RF_B_sel),
        .Imm_mode  (Imm_mode),
        .Wb_WrEn   (Wb_WrEn),
        .Wb_Addr   (Wb_Addr),
        .Wb_Data   (Wb_Data),
        .Flush     (Flush),
        .Out_valid (Out_valid),
        .Out_ready (Out_ready),
        .Immed     (Immed),
        .RF_A      (RF_A),
        .RF_B      (RF_B),
        .Rt_addr   (Rt_addr)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mk(input int rs, input int rt, input logic [15:0] imm);
        logic [4:0] r1;
        logic [4:0] r2;
        r1 = rs[4:0];
        r2 = rt[4:0];
        return {6'd0, r1, r2, imm};
    endfunction

    function automatic logic [31:0] m_imm(input logic [1:0] mode, input logic [15:0] imm);
        longint u;
        longint s;
        longint v;
        u = longint'(imm);
        s = (imm >= 16'h8000) ? u - 65536 : u;
        case (mode)
            2'd0:    v = u;
            2'd1:    v = s;
            2'd2:    v = u * 65536;
            default: v = s * 4;
        endcase
        return v[31:0];
    endfunction

    function automatic logic [31:0] m_read(input int idx);
        if (idx == 0) return 32'd0;
`ifdef DECSTAGE_BYPASS_EN
        if (Wb_WrEn && (int'(Wb_Addr) == idx)) return Wb_Data;
`endif
        return ref_rf[idx];
    endfunction

    // One clock: check In_ready, predict, clock, then compare registered outputs.
    task automatic step();
        logic        exp_rdy;
        logic        acc;
        logic        n_valid;
        logic [31:0] n_imm, n_a, n_b;
        logic [4:0]  n_rt;
        int          rs, rt, rd;
        #1;
        exp_rdy = !m_valid || Out_ready;
        chk("in_ready", {63'd0, In_ready}, {63'd0, exp_rdy});
        acc = In_valid && exp_rdy;
        rs = int'(Instr[25:21]);
        rt = int'(Instr[20:16]);
        rd = int'(Instr[15:11]);
        n_valid = m_valid;
        n_imm = m_imm_q; n_a = m_a; n_b = m_b; n_rt = m_rt;
        if (Rst) begin
            n_valid = 1'b0;
            n_imm = 0; n_a = 0; n_b = 0; n_rt = 0;
        end else begin
            if (Flush) n_valid = 1'b0;
            else if (acc) n_valid = 1'b1;
            else if (Out_ready) n_valid = 1'b0;
            if (acc && !Flush) begin
                n_imm = m_imm(Imm_mode, Instr[15:0]);
                n_a   = m_read(rs);
                n_b   = m_read(RF_B_sel ? rt : rd);
                n_rt  = Instr[20:16];
            end
        end
        if (Rst) begin
            for (int i = 0; i < 32; i++) ref_rf[i] = 32'd0;
        end else if (Wb_WrEn && Wb_Addr != 5'd0) begin
            ref_rf[Wb_Addr] = Wb_Data;
        end
        @(posedge Clk);
        #1;
        m_valid = n_valid; m_imm_q = n_imm; m_a = n_a; m_b = n_b; m_rt = n_rt;
        chk("out_valid", {63'd0, Out_valid}, {63'd0, m_valid});
        if (m_valid) begin
            chk("immed", {32'd0, Immed}, {32'd0, m_imm_q});
            chk("rf_a", {32'd0, RF_A}, {32'd0, m_a});
            chk("rf_b", {32'd0, RF_B}, {32'd0, m_b});
            chk("rt_addr", {59'd0, Rt_addr}, {59'd0, m_rt});
        end
    endtask

    task automatic idle();
        In_valid = 1'b0; Instr = 32'd0; RF_B_sel = 1'b0; Imm_mode = 2'd0;
        Wb_WrEn = 1'b0; Wb_Addr = 5'd0; Wb_Data = 32'd0; Flush = 1'b0; Out_ready = 1'b1;
    endtask

    initial begin
        logic [31:0] imm_exp [4];
        logic [31:0] old7;
        imm_exp[0] = 32'h00008004;
        imm_exp[1] = 32'hFFFF8004;
        imm_exp[2] = 32'h80040000;
        imm_exp[3] = 32'hFFFE0010;
        m_valid = 1'b0; m_imm_q = 0; m_a = 0; m_b = 0; m_rt = 0;
        for (int i = 0; i < 32; i++) ref_rf[i] = 32'd0;

        idle();
        Rst = 1'b1;
        step();
        step();
        Rst = 1'b0;
        step();
        chk("rst_out_valid", {63'd0, Out_valid}, 64'd0);
        chk("rst_rf_a", {32'd0, RF_A}, 64'd0);
        chk("rst_rf_b", {32'd0, RF_B}, 64'd0);
        chk("rst_immed", {32'd0, Immed}, 64'd0);
        chk("rst_in_ready", {63'd0, In_ready}, 64'd1);

        for (int m = 0; m < 4; m++) begin
            idle();
            In_valid = 1'b1;
            Instr = mk(0, 0, 16'h8004);
            Imm_mode = 2'(m);
            step();
            chk("imm_mode", {32'd0, Immed}, {32'd0, imm_exp[m]});
        end

        idle();
        Wb_WrEn = 1'b1; Wb_Addr = 5'd5; Wb_Data = 32'hDEADBEEF;
        step();
        idle();
        In_valid = 1'b1; Instr = mk(5, 0, 16'h0001);
        step();
        chk("wr_then_rd", {32'd0, RF_A}, 64'hDEADBEEF);

        idle();
        Wb_WrEn = 1'b1; Wb_Addr = 5'd0; Wb_Data = 32'h12345678;
        step();
        idle();
        In_valid = 1'b1; Instr = mk(0, 5, 16'h0002); RF_B_sel = 1'b1;
        step();
        chk("reg0_read", {32'd0, RF_A}, 64'd0);
        chk("rt_read", {32'd0, RF_B}, 64'hDEADBEEF);

        idle();
        In_valid = 1'b1; Instr = mk(5, 3, 16'h1111);
        step();
        Instr = mk(0, 9, 16'h2222); Out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("bp_in_ready", {63'd0, In_ready}, 64'd0);
            chk("bp_hold", {32'd0, Immed}, 64'h1111);
        end
        Out_ready = 1'b1;
        step();
        chk("bp_release", {32'd0, Immed}, 64'h2222);
        chk("bp_rt", {59'd0, Rt_addr}, 64'd9);

        idle();
        In_valid = 1'b1; Flush = 1'b1; Instr = mk(5, 1, 16'h3333);
        step();
        chk("flush_kill", {63'd0, Out_valid}, 64'd0);

        idle();
        Wb_WrEn = 1'b1; Wb_Addr = 5'd7; Wb_Data = 32'h11111111;
        step();
        old7 = 32'h11111111;
        idle();
        Wb_WrEn = 1'b1; Wb_Addr = 5'd7; Wb_Data = 32'h22222222;
        In_valid = 1'b1; Instr = mk(7, 0, 16'h0004);
        step();
`ifdef DECSTAGE_BYPASS_EN
        chk("bypass_idx7", {32'd0, RF_A}, 64'h22222222);
`else
        chk("bypass_idx7", {32'd0, RF_A}, {32'd0, old7});
`endif

        for (int n = 0; n < 400; n++) begin
            In_valid  = ($urandom_range(0, 3) != 0);
            Out_ready = ($urandom_range(0, 3) != 0);
            Flush     = ($urandom_range(0, 7) == 0);
            Instr     = $urandom;
            RF_B_sel  = 1'($urandom_range(0, 1));
            Imm_mode  = 2'($urandom_range(0, 3));
            Wb_WrEn   = 1'($urandom_range(0, 1));
            Wb_Addr   = 5'($urandom_range(0, 31));
            Wb_Data   = $urandom;
            Rst       = (n == 200);
            step();
        end
        Rst = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
